muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers, completing the MIPS mult/div path. It executes MULT, MULTU, DIV and DIVU over 32 iteration cycles and holds the 64-bit product or quotient/remainder in HI/LO. It also accepts MTHI/MTLO writes. The datapath reads `hi`/`lo` for MFHI/MFLO and stalls the core on `busy`.

## Interface
- No parameters; data width fixed at 32.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: request; sampled only in IDLE.
- `op` in 3: operation code (`md_op_t`), sampled with `start`.
- `a` in 32: rs operand (multiplicand / dividend / MT data).
- `b` in 32: rt operand (multiplier / divisor).
- `busy` out 1: operation in flight; core stalls MFHI/MFLO and new mult/div.
- `done` out 1: one-cycle pulse; `hi`/`lo` hold the new result.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- States: IDLE, CALC, FINISH.
- **IDLE**
  - `start` with op MULT/MULTU/DIV/DIVU: latch operands, clear the iteration counter, go to CALC.
  - `start` with MTHI/MTLO: write `a` to hi/lo at that edge; stay in IDLE; no busy, no done.
  - op codes 110/111: ignored.
- **CALC**: 32 iterations, one bit per cycle, 6-bit counter 0..31; counter==31 goes to FINISH.
  - Signed ops use operand magnitudes internally.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring, 33-bit subtract of the partial remainder against |b|.
- **FINISH**
  - Sign fix-up:
    - Signed product: negated if operand signs differ.
    - Signed quotient: negated if signs differ.
    - Signed remainder: takes the sign of the dividend.
  - Write hi/lo at the end of the cycle, go to IDLE.
  - MULT/MULTU: hi = product[63:32], lo = product[31:0].
  - DIV/DIVU: lo = quotient, hi = remainder.
- **Divide by zero** (b==0, DIV or DIVU): runs full latency; lo = 0xFFFFFFFF, hi = original `a`.
- **0x80000000 / 0xFFFFFFFF (DIV)**: lo = 0x80000000, hi = 0; wraps naturally, no trap.
- **`start` while busy**: ignored; no queuing.
- **Reset**
  - Any state goes to IDLE; hi = lo = 0, busy = 0, done = 0.
  - An in-flight operation is discarded.
- Reset values of every output are 0.

## Timing
- `start` sampled at edge N (IDLE).
- `busy` is high cycles N+1 .. N+33: 32 CALC cycles plus 1 FINISH cycle.
- `hi`/`lo` update at the end of cycle N+33.
- `done` is high for cycle N+34 only; the unit is back in IDLE.
- `busy` is a decode of state (not IDLE); `done` is registered.
- Back-to-back: `start` is accepted in the `done` cycle (N+34).
- MTHI/MTLO: `hi`/`lo` are visible the cycle after the `start` edge.

## Structure
- Package `muldiv_pkg` holds:
  - `typedef enum logic [2:0] md_op_t`: MD_MULT=000, MD_MULTU=001, MD_DIV=010, MD_DIVU=011, MD_MTHI=100, MD_MTLO=101.
  - `typedef enum logic [1:0] md_state_t`: IDLE, CALC, FINISH.
  - `localparam MD_ITER = 32`.
- One natural sub-module, `muldiv_step`: combinational single iteration.
  - Inputs: accumulator, operand, mode.
  - Outputs: next accumulator.
  - Serves both the add path and the compare-subtract path.
- Top level holds the FSM, counter, sign flags and HI/LO registers.

## Test plan
- MULT a=0xFFFFFFFE, b=3: busy N+1..N+33, done at N+34, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=b=0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2: lo=3, hi=1.
- Divide boundary cases:
  - DIVU a=0x12345678, b=0: lo=0xFFFFFFFF, hi=0x12345678.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Start and reset mid-operation:
  - Second `start` (MULT 5×5) at N+5 while busy: ignored; first result unchanged.
  - `reset` pulse at N+10: busy=0, hi=lo=0, no done pulse.
- MTHI a=0xDEADBEEF: hi=0xDEADBEEF next cycle, busy stays 0, done stays 0. A subsequent DIVU issued in the same cycle as a `done` pulse is accepted.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  // Operation codes presented on the op port together with start.
  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_t;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } md_state_t;

  // Selects which datapath a single iteration exercises.
  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } md_step_mode_t;

  // One result bit is produced per CALC cycle.
  localparam int MD_ITER = 32;

  // Magnitude of a 32-bit operand; unsigned operands pass through untouched.
  // |0x80000000| is 0x80000000 read as unsigned, which the datapath expects.
  function automatic logic [31:0] md_abs(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the shared multiply/divide datapath.
//
// Multiply: acc = {partial_product_hi, multiplier_remaining}. If the low bit of
// the multiplier is set the operand is added into the upper half, then the
// whole 65-bit {carry, acc} shifts right one place.
//
// Divide (restoring): acc = {partial_remainder, dividend_remaining}. The next
// dividend bit is shifted into the remainder, a 33-bit subtract against the
// divisor decides the quotient bit, and the quotient bit enters at the bottom.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic [63:0]   acc_i,
  input  logic [31:0]   operand_i,
  input  md_step_mode_t mode_i,
  output logic [63:0]   acc_o
);

  logic [32:0] add_sum;
  logic [32:0] rem_shift;
  logic [32:0] sub_diff;
  logic        sub_ok;

  // Evaluate both paths and select the one for the current operation.
  always_comb begin
    add_sum   = {1'b0, acc_i[63:32]} + {1'b0, (acc_i[0] ? operand_i : 32'd0)};
    rem_shift = {acc_i[63:32], acc_i[31]};
    sub_diff  = rem_shift - {1'b0, operand_i};
    sub_ok    = (rem_shift >= {1'b0, operand_i});
    if (mode_i == STEP_DIV) begin
      // A restored remainder is always below the divisor, so 32 bits suffice.
      // With a zero divisor every subtract "succeeds" and the remainder just
      // collects the dividend bits, which the top level overrides anyway.
      acc_o = {(sub_ok ? sub_diff[31:0] : rem_shift[31:0]), acc_i[30:0], sub_ok};
    end else begin
      acc_o = {add_sum, acc_i[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take 32 CALC cycles plus one FINISH cycle; MTHI/MTLO
// write HI/LO directly from IDLE without going busy.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_t     state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [63:0]   acc_q;
  logic [31:0]   operand_q;
  md_step_mode_t mode_q;
  logic          neg_res_q;
  logic          neg_rem_q;
  logic          div_zero_q;
  logic [31:0]   a_orig_q;
  logic [31:0]   hi_q, lo_q;
  logic          done_q;

  // Operation decode of the incoming request.
  logic        op_is_md;
  logic        op_signed;
  logic        op_div;
  logic        accept_md;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  // Datapath results.
  logic [63:0] acc_step;
  logic [63:0] prod_fixed;
  logic [31:0] quot_fixed;
  logic [31:0] rem_fixed;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // Decode op and form operand magnitudes for a new request.
  always_comb begin
    op_is_md  = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    op_signed = (op == MD_MULT) || (op == MD_DIV);
    op_div    = (op == MD_DIV)  || (op == MD_DIVU);
    accept_md = start && op_is_md && (state_q == IDLE);
    abs_a     = md_abs(a, op_signed);
    abs_b     = md_abs(b, op_signed);
  end

  muldiv_step u_step (
    .acc_i     (acc_q),
    .operand_i (operand_q),
    .mode_i    (mode_q),
    .acc_o     (acc_step)
  );

  // Next-state and iteration counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_md) begin
          state_d = CALC;
          cnt_d   = 6'd0;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(MD_ITER - 1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sign fix-up and HI/LO selection for the completed operation.
  always_comb begin
    prod_fixed = neg_res_q ? (~acc_q + 64'd1) : acc_q;
    quot_fixed = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fixed  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    if (mode_q == STEP_MUL) begin
      res_hi = prod_fixed[63:32];
      res_lo = prod_fixed[31:0];
    end else if (div_zero_q) begin
      res_hi = a_orig_q;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = rem_fixed;
      res_lo = quot_fixed;
    end
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand capture on accept, then one datapath iteration per CALC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= 64'd0;
      operand_q  <= 32'd0;
      mode_q     <= STEP_MUL;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      a_orig_q   <= 32'd0;
    end else if (accept_md) begin
      // Multiply keeps the multiplier in the low half and adds the
      // multiplicand; divide keeps the dividend low and subtracts the divisor.
      acc_q      <= {32'd0, (op_div ? abs_a : abs_b)};
      operand_q  <= op_div ? abs_b : abs_a;
      mode_q     <= op_div ? STEP_DIV : STEP_MUL;
      neg_res_q  <= op_signed && (a[31] ^ b[31]);
      neg_rem_q  <= op_signed && op_div && a[31];
      div_zero_q <= op_div && (b == 32'd0);
      a_orig_q   <= a;
    end else if (state_q == CALC) begin
      acc_q <= acc_step;
    end
  end

  // Architectural HI/LO: written at the end of FINISH or by MTHI/MTLO in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (state_q == FINISH) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if (start && (state_q == IDLE)) begin
      if (op == MD_MTHI) begin
        hi_q <= a;
      end else if (op == MD_MTLO) begin
        lo_q <= a;
      end
    end
  end

  // Completion pulse, registered so it lands in the cycle after FINISH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == FINISH);
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO pairs, a
// negedge monitor pops and compares them whenever done pulses.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  string       name_q[$];
  logic [63:0] mon_exp;
  string       mon_name;

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done with hi=%h lo=%h expected no done", hi, lo);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        chk({mon_name, "_hi"}, hi, mon_exp[63:32]);
        chk({mon_name, "_lo"}, lo, mon_exp[31:0]);
      end
    end
  end

  // Issue one mult/div at the current negedge and follow it to its done cycle.
  // Returns at the negedge of the done cycle so the next call is back-to-back.
  task automatic run_op(input string nm, input logic [2:0] opc, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo,
                        input bit inject);
    int busy_cnt = 0;
    int done_cnt = 0;
    exp_q.push_back({ehi, elo});
    name_q.push_back(nm);
    start = 1'b1;
    op    = opc;
    a     = av;
    b     = bv;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (inject && i == 5) begin
        // Competing MULT 5x5 sampled at edge N+5 while busy; must be dropped.
        start = 1'b1;
        op    = MD_MULT;
        a     = 32'd5;
        b     = 32'd5;
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
    end
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
    chk({nm, "_early_done"}, 32'(done_cnt), 32'd0);
    chk({nm, "_done_n34"}, 32'(done), 32'd1);
    chk({nm, "_idle_n34"}, 32'(busy), 32'd0);
    $display("op %s a=%h b=%h -> hi=%h lo=%h", nm, av, bv, hi, lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    reset = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("mult_neg2x3",  MD_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    run_op("multu_max",    MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("div_m7_2",     MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_7_2_inj", MD_DIVU,  32'd7,         32'd2,        32'd1,         32'd3,         1'b1);
    run_op("divu_by0",     MD_DIVU,  32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
    run_op("div_ovf",      MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("mult_min_sq",  MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op("div_100_m7",   MD_DIV,   32'd100,       32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2, 1'b0);
    run_op("div_m100_7",   MD_DIV,   32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);

    // MTHI: visible next cycle, no busy, no done, LO untouched.
    start = 1'b1;
    op    = MD_MTHI;
    a     = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    chk("mthi_hi", hi, 32'hDEAD_BEEF);
    chk("mthi_lo", lo, 32'hFFFF_FFF2);
    chk("mthi_busy", 32'(busy), 32'd0);
    chk("mthi_done", 32'(done), 32'd0);
    $display("op mthi a=%h -> hi=%h lo=%h", 32'hDEAD_BEEF, hi, lo);

    run_op("divu_100_7",   MD_DIVU,  32'd100,       32'd7,        32'd2,         32'h0000_000E, 1'b0);
    run_op("divu_max_16",  MD_DIVU,  32'hFFFF_FFFF, 32'd16,       32'h0000_000F, 32'h0FFF_FFFF, 1'b0);

    // MTLO writes only LO.
    start = 1'b1;
    op    = MD_MTLO;
    a     = 32'h0123_4567;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h0123_4567);
    chk("mtlo_hi", hi, 32'h0000_000F);
    chk("mtlo_busy", 32'(busy), 32'd0);
    $display("op mtlo a=%h -> hi=%h lo=%h", 32'h0123_4567, hi, lo);

    // Reserved op code 110 is ignored.
    start = 1'b1;
    op    = 3'b110;
    a     = 32'hAAAA_AAAA;
    b     = 32'd1;
    @(negedge clk);
    start = 1'b0;
    chk("op110_busy", 32'(busy), 32'd0);
    chk("op110_hi", hi, 32'h0000_000F);
    chk("op110_lo", lo, 32'h0123_4567);
    $display("op 110 a=%h -> hi=%h lo=%h", 32'hAAAA_AAAA, hi, lo);

    // Reset pulse at N+10 discards the in-flight MULTU.
    start = 1'b1;
    op    = MD_MULTU;
    a     = 32'hFFFF_FFFF;
    b     = 32'hFFFF_FFFF;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    chk("rst_mid_no_done", 32'(dcnt), 32'd0);
    chk("rst_mid_hi_after", hi, 32'd0);
    $display("op multu aborted by reset -> hi=%h lo=%h", hi, lo);

    run_op("mult_m7x3",    MD_MULT,  32'hFFFF_FFF9, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

    @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
